instr_loader: RTL and testbench

//  Boot-time writer for the CPU instruction-memory load port (instruction_in/load_instruction).

---
 rtl/instr_loader_pkg.sv | 28 ++
 rtl/instr_loader_if.sv | 22 ++
 rtl/loader_timeout.sv | 31 +++
 rtl/instr_loader.sv | 145 ++++++++++++++
 tb/tb_instr_loader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types for the boot-time instruction loader: FSM states, word width
// and state-decode helpers used by the loader and its bench.
package instr_loader_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [3:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      WRITE,
      CSUM,
      RELEASE,
      DONE,
      ERROR
   } state_t;

   function automatic logic accepts_bytes(input state_t s);
      return s inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};
   endfunction

   function automatic logic is_busy(input state_t s);
      return !(s inside {IDLE, DONE, ERROR});
   endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream handshake from the host link plus the instruction-memory load port.
interface instr_loader_if #(parameter int ADDR_W = 8);
   import instr_loader_pkg::*;

   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic [WORD_W-1:0] instruction_out;
   logic [ADDR_W-1:0] load_addr;
   logic              load_instruction;

   modport master (
      output byte_in, byte_valid,
      input  byte_ready, instruction_out, load_addr, load_instruction
   );

   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, instruction_out, load_addr, load_instruction
   );

endinterface

// File: rtl/loader_timeout.sv
// Idle-gap watchdog: counts cycles the loader waits for a byte and flags
// expiry once TIMEOUT such cycles pass without a clear.
module loader_timeout #(
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] count;

   // Saturates at the limit so expired stays asserted until cleared.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count != LIMIT) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/instr_loader.sv
// Boot-time loader: takes a framed byte stream, writes 16-bit words into
// instruction memory and releases the CPU reset only when the checksum matches.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DEPTH   = 256,
   parameter int TIMEOUT = 1000
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   instr_loader_if.slave bus,
   output logic          pc_reset,
   output logic          busy,
   output logic          done,
   output logic          error
);

   state_t            state;
   logic [15:0]       word_count;
   logic [7:0]        hi_byte;
   logic [7:0]        csum;
   logic [ADDR_W-1:0] index;
   logic              transfer;
   logic              expired;
   logic              timer_clear;
   logic              timer_enable;
   logic [15:0]       rx_len;
   logic              last_word;

   assign bus.byte_ready = accepts_bytes(state);
   assign busy           = is_busy(state);
   assign transfer       = bus.byte_valid & bus.byte_ready;
   assign bus.load_addr  = index;
   assign rx_len         = {word_count[15:8], bus.byte_in};
   assign last_word      = (16'(index) == (word_count - 16'd1));
   assign timer_clear    = transfer | ~busy;
   assign timer_enable   = bus.byte_ready & ~bus.byte_valid;

   loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (expired)
   );

   // A timeout takes priority over everything, including a stray start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                <= IDLE;
         word_count           <= '0;
         hi_byte              <= '0;
         csum                 <= '0;
         index                <= '0;
         bus.instruction_out  <= '0;
         bus.load_instruction <= 1'b0;
         pc_reset             <= 1'b1;
         done                 <= 1'b0;
         error                <= 1'b0;
      end else begin
         bus.load_instruction <= 1'b0;
         if (busy && expired) begin
            state <= ERROR;
            error <= 1'b1;
         end else begin
            case (state)
               IDLE, DONE, ERROR: begin
                  if (start) begin
                     state    <= LEN_HI;
                     done     <= 1'b0;
                     error    <= 1'b0;
                     pc_reset <= 1'b1;
                     csum     <= '0;
                     index    <= '0;
                  end
               end
               LEN_HI: begin
                  if (transfer) begin
                     word_count[15:8] <= bus.byte_in;
                     state            <= LEN_LO;
                  end
               end
               LEN_LO: begin
                  if (transfer) begin
                     word_count <= rx_len;
                     if (rx_len > 16'(DEPTH)) begin
                        state <= ERROR;
                        error <= 1'b1;
                     end else if (rx_len == 16'd0) begin
                        state <= CSUM;
                     end else begin
                        state <= DATA_HI;
                     end
                  end
               end
               DATA_HI: begin
                  if (transfer) begin
                     hi_byte <= bus.byte_in;
                     csum    <= csum ^ bus.byte_in;
                     state   <= DATA_LO;
                  end
               end
               DATA_LO: begin
                  if (transfer) begin
                     bus.instruction_out  <= {hi_byte, bus.byte_in};
                     bus.load_instruction <= 1'b1;
                     csum                 <= csum ^ bus.byte_in;
                     state                <= WRITE;
                  end
               end
               WRITE: begin
                  // Index stops at N-1 so a full DEPTH image never wraps to 0.
                  if (last_word) begin
                     state <= CSUM;
                  end else begin
                     index <= index + ADDR_W'(1);
                     state <= DATA_HI;
                  end
               end
               CSUM: begin
                  if (transfer) begin
                     if (bus.byte_in == csum) begin
                        state <= RELEASE;
                     end else begin
                        state <= ERROR;
                        error <= 1'b1;
                     end
                  end
               end
               RELEASE: begin
                  pc_reset <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed and randomized frames checked
// against a frame-level model (expected writes, XOR checksum, outcome flags).
module tb_instr_loader;

   localparam int ADDR_W     = 8;
   localparam int DEPTH      = 256;
   localparam int TIMEOUT    = 1000;
   localparam int READY_WAIT = 100;

   logic clk = 1'b0;
   logic reset_n;
   logic start;
   logic pc_reset;
   logic busy;
   logic done;
   logic error;

   instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

   instr_loader #(
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .bus      (bus),
      .pc_reset (pc_reset),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] frame_words[$];
   logic [31:0] seen_addr[$];
   logic [15:0] seen_data[$];

   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.load_instruction === 1'b1) begin
         seen_addr.push_back(32'(bus.load_addr));
         seen_data.push_back(bus.instruction_out);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] value, input int gap);
      int waited;
      waited = 0;
      repeat (gap) @(negedge clk);
      bus.byte_in    = value;
      bus.byte_valid = 1'b1;
      while (bus.byte_ready !== 1'b1 && waited < READY_WAIT) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("byte_ready_for_byte", 32'(bus.byte_ready), 32'd1);
      @(negedge clk);
      bus.byte_valid = 1'b0;
   endtask

   function automatic int pickGap(input int max_gap);
      if (max_gap <= 0) return 0;
      return int'($urandom_range(0, max_gap));
   endfunction

   function automatic logic [7:0] frameXor();
      logic [7:0] x;
      x = 8'h00;
      foreach (frame_words[i]) x = x ^ frame_words[i][15:8] ^ frame_words[i][7:0];
      return x;
   endfunction

   // One complete load of frame_words with the given length field and checksum byte.
   task automatic applyStimulus(input logic [15:0] len_field, input logic [7:0] csum_byte,
                                input int max_gap, input bit poke_start);
      bit overflow;
      bit good;
      int expected_writes;
      overflow        = (len_field > 16'(DEPTH));
      good            = !overflow && (csum_byte == frameXor());
      expected_writes = overflow ? 0 : frame_words.size();
      seen_addr.delete();
      seen_data.delete();

      pulseStart();
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      checkOutput("done_cleared_on_start", 32'(done), 32'd0);
      checkOutput("error_cleared_on_start", 32'(error), 32'd0);
      checkOutput("pc_reset_on_start", 32'(pc_reset), 32'd1);

      sendByte(len_field[15:8], pickGap(max_gap));
      if (poke_start) pulseStart();
      sendByte(len_field[7:0], pickGap(max_gap));
      if (!overflow) begin
         foreach (frame_words[i]) begin
            sendByte(frame_words[i][15:8], pickGap(max_gap));
            sendByte(frame_words[i][7:0], pickGap(max_gap));
         end
         sendByte(csum_byte, pickGap(max_gap));
      end

      if (good) begin
         checkOutput("pc_reset_held_in_release", 32'(pc_reset), 32'd1);
         checkOutput("done_not_before_release", 32'(done), 32'd0);
         @(negedge clk);
      end
      checkOutput("done", 32'(done), 32'(good));
      checkOutput("error", 32'(error), 32'(!good));
      checkOutput("pc_reset", 32'(pc_reset), 32'(!good));
      checkOutput("busy_after_frame", 32'(busy), 32'd0);
      checkOutput("byte_ready_after_frame", 32'(bus.byte_ready), 32'd0);

      repeat (4) @(negedge clk);
      checkOutput("write_count", 32'(seen_addr.size()), 32'(expected_writes));
      for (int i = 0; i < expected_writes && i < seen_addr.size(); i++) begin
         checkOutput("write_addr", seen_addr[i], 32'(i));
         checkOutput("write_data", 32'(seen_data[i]), 32'(frame_words[i]));
      end
   endtask

   initial begin
      logic [7:0] csum_byte;
      int n;

      reset_n        = 1'b0;
      start          = 1'b0;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("reset_pc_reset", 32'(pc_reset), 32'd1);
      checkOutput("reset_byte_ready", 32'(bus.byte_ready), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_error", 32'(error), 32'd0);
      checkOutput("reset_load_instruction", 32'(bus.load_instruction), 32'd0);
      checkOutput("reset_load_addr", 32'(bus.load_addr), 32'd0);
      checkOutput("reset_instruction_out", 32'(bus.instruction_out), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_pc_reset", 32'(pc_reset), 32'd1);

      $display("[TB] good two-word frame");
      frame_words = '{16'h1234, 16'hABCD};
      applyStimulus(16'd2, 8'h40, 0, 1'b0);

      $display("[TB] bad checksum");
      applyStimulus(16'd2, 8'h41, 0, 1'b0);

      $display("[TB] oversize length");
      applyStimulus(16'h0101, 8'h00, 0, 1'b0);

      $display("[TB] stall until timeout");
      frame_words = '{16'h5A5A, 16'h0F0F, 16'hC3C3};
      pulseStart();
      sendByte(8'h00, 0);
      sendByte(8'h03, 0);
      sendByte(8'h5A, 0);
      repeat (TIMEOUT - 10) @(negedge clk);
      checkOutput("no_error_before_timeout", 32'(error), 32'd0);
      checkOutput("busy_during_stall", 32'(busy), 32'd1);
      repeat (20) @(negedge clk);
      checkOutput("error_at_timeout", 32'(error), 32'd1);
      checkOutput("done_at_timeout", 32'(done), 32'd0);
      checkOutput("pc_reset_at_timeout", 32'(pc_reset), 32'd1);
      checkOutput("busy_at_timeout", 32'(busy), 32'd0);
      frame_words = '{16'h1234, 16'hABCD};
      applyStimulus(16'd2, 8'h40, 0, 1'b0);

      $display("[TB] empty frame");
      frame_words.delete();
      applyStimulus(16'd0, 8'h00, 0, 1'b0);

      $display("[TB] two-word frame with gaps and ignored start");
      frame_words = '{16'h1234, 16'hABCD};
      applyStimulus(16'd2, 8'h40, 20, 1'b1);

      $display("[TB] random frames");
      for (int f = 0; f < 6; f++) begin
         n = int'($urandom_range(0, 4));
         frame_words.delete();
         for (int w = 0; w < n; w++) frame_words.push_back(16'($urandom));
         csum_byte = frameXor();
         if ($urandom_range(0, 2) == 0) csum_byte = csum_byte ^ 8'($urandom_range(1, 255));
         applyStimulus(16'(n), csum_byte, int'($urandom_range(0, 5)), f[0]);
      end

      $display("[TB] reset during a write");
      frame_words = '{16'hBEEF, 16'h0001, 16'h0002, 16'h0003};
      pulseStart();
      sendByte(8'h00, 0);
      sendByte(8'h04, 0);
      sendByte(8'hBE, 0);
      sendByte(8'hEF, 0);
      checkOutput("strobe_before_reset", 32'(bus.load_instruction), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_pc_reset", 32'(pc_reset), 32'd1);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_done", 32'(done), 32'd0);
      checkOutput("midreset_error", 32'(error), 32'd0);
      checkOutput("midreset_byte_ready", 32'(bus.byte_ready), 32'd0);
      checkOutput("midreset_load_instruction", 32'(bus.load_instruction), 32'd0);
      checkOutput("midreset_instruction_out", 32'(bus.instruction_out), 32'd0);
      checkOutput("midreset_load_addr", 32'(bus.load_addr), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("[TB] recovery frame");
      frame_words = '{16'h7E81};
      applyStimulus(16'd1, 8'hFF, 3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
